// File: rtl/reg_share_arbiter.sv
// ============================================================================
// Module   : reg_share_arbiter
// Purpose  : Round-robin arbiter that lets 4 requesters write one shared
//            register through an IDLE -> GRANT -> ACK handshake.
// Options  : REG_ARB_PARITY_EN adds the registered even-parity output dataPar.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_share_arbiter #(
  parameter int NBITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*NBITS-1:0] dataIn,
  output logic [3:0]         grant,
  output logic [3:0]         ack,
  output logic [NBITS-1:0]   dataReg,
  output logic [1:0]         owner,
  output logic               busy
`ifdef REG_ARB_PARITY_EN
  ,
  output logic               dataPar
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_win;
  logic [1:0]       r_ptr;
  logic [1:0]       r_owner;
  logic [3:0]       r_grant;
  logic [3:0]       r_ack;
  logic [NBITS-1:0] r_data;
  logic [NBITS-1:0] w_lane [4];
  logic [1:0]       w_pick;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane[gi] = dataIn[gi*NBITS +: NBITS];
  end

  // Walk downward so the request closest to the pointer is the last to win.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign w_pick = rr_pick(req, r_ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_win   <= 2'd0;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
      r_grant <= 4'd0;
      r_ack   <= 4'd0;
      r_data  <= '0;
    end else begin
      r_ack <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_win   <= w_pick;
            r_grant <= 4'b0001 << w_pick;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_grant <= 4'd0;
          // A withdrawn request aborts with no side effects at all.
          if (req[r_win]) begin
            r_data  <= w_lane[r_win];
            r_ack   <= 4'b0001 << r_win;
            r_owner <= r_win;
            r_ptr   <= r_win + 2'd1;
            r_state <= S_ACK;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_grant <= 4'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef REG_ARB_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (r_state == S_GRANT && req[r_win]) begin
      r_par <= ^w_lane[r_win];
    end
  end

  assign dataPar = r_par;
`endif

  assign grant   = r_grant;
  assign ack     = r_ack;
  assign dataReg = r_data;
  assign owner   = r_owner;
  assign busy    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_reg_share_arbiter.sv
// ============================================================================
// Module   : tb_reg_share_arbiter
// Purpose  : Self-checking bench for reg_share_arbiter (vector table, corner
//            sequences, randomized run against a cycle reference model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_share_arbiter;

  logic        clk = 1'b0;
  logic        tb_rst = 1'b1;
  logic [3:0]  tb_req = 4'd0;
  logic [31:0] tb_din = 32'd0;
  logic [3:0]  tb_grant;
  logic [3:0]  tb_ack;
  logic [7:0]  tb_data;
  logic [1:0]  tb_owner;
  logic        tb_busy;
`ifdef REG_ARB_PARITY_EN
  logic        tb_par;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_share_arbiter #(.NBITS(8)) dut (
    .clk     (clk),
    .rst     (tb_rst),
    .req     (tb_req),
    .dataIn  (tb_din),
    .grant   (tb_grant),
    .ack     (tb_ack),
    .dataReg (tb_data),
    .owner   (tb_owner),
    .busy    (tb_busy)
`ifdef REG_ARB_PARITY_EN
    ,
    .dataPar (tb_par)
`endif
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] lanes;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_data;
    logic [1:0]  exp_owner;
  } vec_t;

  vec_t tv[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tb_rst = 1'b1;
    tb_req = 4'd0;
    tick();
    tick();
    tb_rst = 1'b0;
  endtask

  // Full write from IDLE: grant next cycle, ack plus data the cycle after.
  task automatic do_txn(input logic [3:0] r, input logic [31:0] lanes,
                        input logic [3:0] eg, input logic [7:0] ed,
                        input logic [1:0] eo, input string tag);
    tb_req = r;
    tb_din = lanes;
    tick();
    chk({tag, "_grant"}, 32'(tb_grant), 32'(eg));
    chk({tag, "_busy_g"}, 32'(tb_busy), 32'd1);
    chk({tag, "_ack_g"}, 32'(tb_ack), 32'd0);
    tick();
    chk({tag, "_ack"}, 32'(tb_ack), 32'(eg));
    chk({tag, "_data"}, 32'(tb_data), 32'(ed));
    chk({tag, "_owner"}, 32'(tb_owner), 32'(eo));
    chk({tag, "_grant_a"}, 32'(tb_grant), 32'd0);
    tb_req = 4'd0;
    tick();
    chk({tag, "_busy_end"}, 32'(tb_busy), 32'd0);
    chk({tag, "_ack_end"}, 32'(tb_ack), 32'd0);
  endtask

  int        m_phase, m_ptr, m_win, m_owner;
  logic [7:0] m_data;
  logic [3:0] e_grant, e_ack;
  int        ack_idx[$];
  int        ack_cyc[$];
  logic [7:0] ack_dat[$];
  int        grant_cyc[$];

  initial begin
    tv[0] = '{4'b0100, 32'h44A52211, 4'b0100, 8'hA5, 2'd2};
    tv[1] = '{4'b0011, 32'h01020304, 4'b0001, 8'h04, 2'd0};
    tv[2] = '{4'b1001, 32'h3C5A6996, 4'b1000, 8'h3C, 2'd3};
    tv[3] = '{4'b1110, 32'hDEADBEEF, 4'b0010, 8'hBE, 2'd1};
    tv[4] = '{4'b0001, 32'h0000007F, 4'b0001, 8'h7F, 2'd0};
    tv[5] = '{4'b1000, 32'h80000001, 4'b1000, 8'h80, 2'd3};

    // Reset held with all requests active must keep everything quiet.
    tb_rst = 1'b1;
    tb_req = 4'b1111;
    tb_din = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_grant", 32'(tb_grant), 32'd0);
      chk("rst_ack", 32'(tb_ack), 32'd0);
      chk("rst_data", 32'(tb_data), 32'd0);
      chk("rst_busy", 32'(tb_busy), 32'd0);
    end
    tb_req = 4'd0;
    tb_rst = 1'b0;

    // Chained vectors: each winner follows from the pointer left by the last.
    for (int i = 0; i < 6; i++)
      do_txn(tv[i].req, tv[i].lanes, tv[i].exp_grant, tv[i].exp_data,
             tv[i].exp_owner, $sformatf("vec%0d", i));

    // Round-robin with all four requesting continuously.
    do_reset();
    tb_req = 4'b1111;
    tb_din = 32'h13121110;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (tb_ack != 4'd0) begin
        ack_idx.push_back($clog2(int'(tb_ack)));
        ack_cyc.push_back(c);
        ack_dat.push_back(tb_data);
      end
      if (tb_grant != 4'd0) grant_cyc.push_back(c);
    end
    tb_req = 4'd0;
    tick();
    tick();
    chk("rr_ack_count", 32'(ack_idx.size()), 32'd5);
    chk("rr_grant_count", 32'(grant_cyc.size()), 32'd5);
    for (int n = 0; n < 5; n++) begin
      if (n < ack_idx.size()) begin
        chk($sformatf("rr_ack_idx%0d", n), 32'(ack_idx[n]), 32'(n % 4));
        chk($sformatf("rr_data%0d", n), 32'(ack_dat[n]), 32'h10 + 32'(n % 4));
        chk($sformatf("rr_ack_cyc%0d", n), 32'(ack_cyc[n]), 32'(2 + 3 * n));
      end
      if (n < grant_cyc.size())
        chk($sformatf("rr_grant_cyc%0d", n), 32'(grant_cyc[n]), 32'(1 + 3 * n));
    end

    // Abort: requester 1 drops during GRANT, then re-requests and wins again.
    do_reset();
    do_txn(4'b0001, 32'h0000775E, 4'b0001, 8'h5E, 2'd0, "ab_pre");
    tb_req = 4'b0010;
    tick();
    chk("ab_grant", 32'(tb_grant), 32'b0010);
    tb_req = 4'd0;
    tick();
    chk("ab_ack", 32'(tb_ack), 32'd0);
    chk("ab_grant_off", 32'(tb_grant), 32'd0);
    chk("ab_data", 32'(tb_data), 32'h5E);
    chk("ab_owner", 32'(tb_owner), 32'd0);
    chk("ab_busy", 32'(tb_busy), 32'd0);
    do_txn(4'b0011, 32'h0000775E, 4'b0010, 8'h77, 2'd1, "ab_retry");

    // Reset during GRANT of requester 3, with the pointer left at 2 beforehand.
    do_reset();
    do_txn(4'b0010, 32'h3C0055E1, 4'b0010, 8'h55, 2'd1, "mr_pre");
    tb_req = 4'b1000;
    tick();
    chk("mr_grant", 32'(tb_grant), 32'b1000);
    tb_rst = 1'b1;
    tick();
    chk("mr_data", 32'(tb_data), 32'd0);
    chk("mr_ack", 32'(tb_ack), 32'd0);
    chk("mr_grant_off", 32'(tb_grant), 32'd0);
    chk("mr_busy", 32'(tb_busy), 32'd0);
    chk("mr_owner", 32'(tb_owner), 32'd0);
    tb_rst = 1'b0;
    do_txn(4'b1001, 32'h3C0055E1, 4'b0001, 8'hE1, 2'd0, "mr_post");

`ifdef REG_ARB_PARITY_EN
    do_reset();
    chk("par_rst", 32'(tb_par), 32'd0);
    do_txn(4'b0001, 32'h00000007, 4'b0001, 8'h07, 2'd0, "par_a");
    chk("par_07", 32'(tb_par), 32'd1);
    do_txn(4'b0010, 32'h00000300, 4'b0010, 8'h03, 2'd1, "par_b");
    chk("par_03", 32'(tb_par), 32'd0);
`endif

    // Randomized run against a cycle-level reference model.
    do_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_win   = 0;
    m_owner = 0;
    m_data  = 8'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tb_rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) tb_req = 4'($urandom_range(0, 15));
      tb_din = $urandom;
      e_grant = 4'd0;
      e_ack   = 4'd0;
      if (tb_rst) begin
        m_phase = 0;
        m_ptr   = 0;
        m_owner = 0;
        m_data  = 8'd0;
      end else if (m_phase == 0) begin
        if (tb_req != 4'd0) begin
          m_win = -1;
          for (int k = 0; k < 4; k++)
            if (m_win < 0 && tb_req[(m_ptr + k) % 4]) m_win = (m_ptr + k) % 4;
          e_grant = 4'(1 << m_win);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (tb_req[m_win]) begin
          m_data  = tb_din[m_win*8 +: 8];
          m_owner = m_win;
          m_ptr   = (m_win + 1) % 4;
          e_ack   = 4'(1 << m_win);
          m_phase = 2;
        end else begin
          m_phase = 0;
        end
      end else begin
        m_phase = 0;
      end
      tick();
      chk("rnd_grant", 32'(tb_grant), 32'(e_grant));
      chk("rnd_ack", 32'(tb_ack), 32'(e_ack));
      chk("rnd_data", 32'(tb_data), 32'(m_data));
      chk("rnd_owner", 32'(tb_owner), 32'(m_owner));
      chk("rnd_busy", 32'(tb_busy), 32'(m_phase != 0));
`ifdef REG_ARB_PARITY_EN
      chk("rnd_par", 32'(tb_par), 32'(^m_data));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter: NBITS, default 8, width of the shared register and of each requester data lane.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester write request; bit i belongs to requester i.
REQ-005 Port: dataIn  input  4*NBITS  data lanes; requester i occupies bits [i*NBITS +: NBITS].
REQ-006 Port: grant  output  4  one-hot grant, registered.
REQ-007 Port: ack  output  4  one-hot, one-cycle write-complete pulse, registered.
REQ-008 Port: dataReg  output  NBITS  shared register contents.
REQ-009 Port: owner  output  2  index of the last requester that completed a write.
REQ-010 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT and ACK.
REQ-012 In IDLE with req==0, the FSM SHALL remain in IDLE with grant=0 and ack=0.
REQ-013 In IDLE with req!=0, the FSM SHALL select a winner w by round-robin, searching from pointer ptr upward modulo 4, and move to GRANT.
  - grant[w] SHALL be 1 in the next cycle.
REQ-014 In GRANT with req[w]=1, the block SHALL:
  - load dataReg with lane w at the clock edge that ends the cycle;
  - move to ACK;
  - drive grant=0 in ACK.
REQ-015 In GRANT with req[w]=0 (withdrawn request), the block SHALL abort:
  - no dataReg write and no ack;
  - ptr and owner unchanged;
  - return to IDLE.
REQ-016 In ACK, the block SHALL:
  - drive ack[w]=1 for exactly one cycle;
  - show the new dataReg value in that same cycle;
  - set owner=w and ptr=(w+1) mod 4;
  - return to IDLE.
REQ-017 Latency SHALL be as follows, with req first sampled in IDLE at cycle T:
  - grant at T+1;
  - dataReg update and ack at T+2;
  - next arbitration at T+3 at the earliest.
REQ-018 A requester still holding req in the IDLE cycle after its ack SHALL be treated as a new request, arbitrated normally.
REQ-019 Changes to req or dataIn while in GRANT or ACK SHALL NOT alter the current winner.
  - Exception: withdrawal of req[w] in GRANT, per REQ-015.
REQ-020 The block SHALL guarantee that at most one bit of grant and one bit of ack is set in any cycle, and that grant and ack are never both nonzero.
REQ-021 dataReg SHALL hold its value in every cycle except the GRANT-to-ACK edge of a non-aborted transaction.

Reset
REQ-022 While rst=1 at a rising edge, the block SHALL clear all state as follows:
  - state to IDLE;
  - ptr, grant, ack, dataReg, owner and busy to 0.
REQ-023 Reset SHALL take priority over every other event, including mid-transaction in GRANT or ACK.
  - No ack pulse is emitted for a transaction killed by reset.
  - No dataReg write occurs for a transaction killed by reset.

Configuration
REQ-024 Macro REG_ARB_PARITY_EN SHALL control the parity feature.
  - Defined: the block adds output port dataPar (1 bit), equal to the even parity (XOR) of dataReg. It is registered, updates on the same edge as dataReg, and resets to 0.
  - Undefined: the dataPar port and its logic are absent; all other behaviour is identical.

Verification
REQ-025 Reset case:
  - Stimulus: hold rst=1 for 3 cycles with req=4'b1111 and all lanes 8'hFF.
  - Required: grant=0, ack=0, dataReg=8'h00, busy=0 throughout.
REQ-026 Single requester:
  - Stimulus: req=4'b0100 with lane2=8'hA5, sampled at T.
  - Required: grant=4'b0100 at T+1; ack=4'b0100, dataReg=8'hA5 and owner=2 at T+2; busy=0 at T+3.
REQ-027 Round-robin fairness:
  - Stimulus: hold req=4'b1111 continuously after reset, with lanes 8'h10, 8'h11, 8'h12, 8'h13.
  - Required: ack order 0,1,2,3,0; dataReg sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10; one grant every 3 cycles.
REQ-028 Abort case:
  - Stimulus: requester 1 granted, then req[1] dropped during GRANT.
  - Required: no ack; dataReg unchanged; owner unchanged; next grant goes to requester 1 again if it re-requests.
REQ-029 Reset mid-transaction:
  - Stimulus: assert rst in the GRANT cycle for requester 3 (lane3=8'h3C).
  - Required: next cycle dataReg=8'h00 and ack=0; after release, arbitration starts from requester 0.
REQ-030 Parity (REG_ARB_PARITY_EN defined):
  - Stimulus: write 8'h07, then 8'h03.
  - Required: dataPar=1 after the 8'h07 write; dataPar=0 after the 8'h03 write.
